// File: rtl/ahb_bridge_arbiter_pkg.sv
// ahb_arb_pkg: shared types for the AHB bridge round-robin arbiter.
// Transfer encodings follow the AHB HTRANS/HRESP field values.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  // IDLE -> ADDR (address phase) -> DATA (data phase) -> COMPLETE -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ADDR     = 2'b01,
    ST_DATA     = 2'b10,
    ST_COMPLETE = 2'b11
  } arb_state_t;

endpackage

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set request
// at or above ptr_i, wrapping to the lowest set request when none is above.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  logic          hi_v;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] any_idx;

  // Descending scan: the last hit written is the lowest index in each region
  always_comb begin
    hi_v    = 1'b0;
    hi_idx  = '0;
    any_idx = '0;
    valid_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        any_idx = IW'(i);
        if (i >= int'(ptr_i)) begin
          hi_v   = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    idx_o = hi_v ? hi_idx : any_idx;
    gnt_o = '0;
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: shares the bridge AHB slave port among NUM_REQ requesters,
// one single-beat NONSEQ transfer at a time, round-robin order.
// Optional wait-state timeout enabled by defining ARB_TIMEOUT_EN.
// Handshake: a requester holds req high until it sees its done bit for one
// cycle, then drops req; gnt is one-hot for the whole transfer.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      Hclk,
  input  logic                      Hresetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic [1:0]                Htrans,
  output logic [ADDR_W-1:0]         Haddr,
  output logic                      Hwrite,
  output logic [DATA_W-1:0]         Hwdata,
  output logic                      Hreadyin,
  input  logic                      Hreadyout,
  input  logic [1:0]                Hresp,
  input  logic [DATA_W-1:0]         Hrdata,
  output logic [1:0]                dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  htrans_t              htrans_q, htrans_d;
  logic [ADDR_W-1:0]    haddr_q, haddr_d;
  logic                 hwrite_q, hwrite_d;
  logic [DATA_W-1:0]    hwdata_q, hwdata_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 hreadyin_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic                 timeout;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_q, wait_d;

  // The wait that would bring the count to TIMEOUT_CYC ends the transfer
  assign timeout = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !Hreadyout &&
                   (wait_q == CW'(TIMEOUT_CYC - 1));

  // Wait counter: cleared while idle (i.e. on entry to ADDR), counts stalls
  always_comb begin
    wait_d = wait_q;
    if (state_q == ST_IDLE) wait_d = '0;
    else if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && !Hreadyout) wait_d = wait_q + 1'b1;
  end

  // Wait counter register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (pick_valid) state_d = ST_ADDR;
      ST_ADDR:     if (timeout) state_d = ST_COMPLETE;
                   else if (Hreadyout) state_d = ST_DATA;
      ST_DATA:     if (timeout || Hreadyout) state_d = ST_COMPLETE;
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and transfer latches
  always_comb begin
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          idx_d    = pick_idx;
          gnt_d    = pick_gnt;
          haddr_d  = req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
          hwrite_d = req_write[pick_idx];
          wdata_d  = req_wdata[int'(pick_idx) * DATA_W +: DATA_W];
          htrans_d = HT_NONSEQ;
        end
      end
      ST_ADDR: begin
        if (timeout) begin
          htrans_d      = HT_IDLE;
          rdata_d       = '0;
          err_d         = 1'b1;
          done_d[idx_q] = 1'b1;
        end else if (Hreadyout) begin
          htrans_d = HT_IDLE;
          hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        if (timeout) begin
          rdata_d       = '0;
          err_d         = 1'b1;
          done_d[idx_q] = 1'b1;
        end else if (Hreadyout) begin
          rdata_d       = hwrite_q ? '0 : Hrdata;
          err_d         = (Hresp == HRESP_ERROR);
          done_d[idx_q] = 1'b1;
        end
      end
      ST_COMPLETE: begin
        gnt_d = '0;
        ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Output and latch registers
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      ptr_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      htrans_q   <= HT_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      hreadyin_q <= 1'b1;
    end else begin
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      hreadyin_q <= 1'b1;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign Htrans    = htrans_q;
  assign Haddr     = haddr_q;
  assign Hwrite    = hwrite_q;
  assign Hwdata    = hwdata_q;
  assign Hreadyin  = hreadyin_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// tb_ahb_bridge_arbiter: directed bench for ahb_bridge_arbiter (NUM_REQ=4,
// 32-bit address/data). Inputs are driven 1ns after the rising edge and
// outputs are checked at that same point, away from the active edge.
module tb_ahb_bridge_arbiter;
  import ahb_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            Hclk = 1'b0;
  logic            Hresetn;
  logic [NR-1:0]   req;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic [1:0]      Htrans;
  logic [AW-1:0]   Haddr;
  logic            Hwrite;
  logic [DW-1:0]   Hwdata;
  logic            Hreadyin;
  logic            Hreadyout;
  logic [1:0]      Hresp;
  logic [DW-1:0]   Hrdata;
  logic [1:0]      dbg_state;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 Hclk = ~Hclk;

  ahb_bridge_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwrite    (Hwrite),
    .Hwdata    (Hwdata),
    .Hreadyin  (Hreadyin),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .dbg_state (dbg_state)
  );

  // Advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]        = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    Hresetn   = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    Hrdata    = '0;
    #12;
    checks++; if (Htrans !== 2'b00 || Haddr !== '0 || Hwrite !== 1'b0 || Hwdata !== '0) begin
      failures++; $display("FAIL reset_bus Htrans=%b Haddr=%h Hwrite=%b Hwdata=%h want 0", Htrans, Haddr, Hwrite, Hwdata); end
    checks++; if (gnt !== 4'b0 || done !== 4'b0 || rdata !== '0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_req gnt=%b done=%b rdata=%h err=%b want 0", gnt, done, rdata, err); end
    checks++; if (Hreadyin !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_misc Hreadyin=%b state=%0d want 1/0", Hreadyin, dbg_state); end
    Hresetn = 1'b1;
    tick();
    tick();
    checks++; if (gnt !== 4'b0 || Htrans !== 2'b00 || Hreadyin !== 1'b1) begin
      failures++; $display("FAIL idle_no_req gnt=%b Htrans=%b Hreadyin=%b want 0/00/1", gnt, Htrans, Hreadyin); end
  endtask

  // Requester 1 writes; pointer is 0 so it wins; pointer becomes 2 afterwards
  task automatic test_single_write();
    set_req(1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010 || Htrans !== 2'b10 || Haddr !== 32'h8000_0010 || Hwrite !== 1'b1) begin
      failures++; $display("FAIL wr_addr gnt=%b Htrans=%b Haddr=%h Hwrite=%b want 0010/10/80000010/1", gnt, Htrans, Haddr, Hwrite); end
    tick();
    checks++; if (Htrans !== 2'b00 || Hwdata !== 32'hDEAD_BEEF || done !== 4'b0) begin
      failures++; $display("FAIL wr_data Htrans=%b Hwdata=%h done=%b want 00/deadbeef/0000", Htrans, Hwdata, done); end
    tick();
    checks++; if (done !== 4'b0010 || err !== 1'b0 || rdata !== '0 || dbg_state !== ST_COMPLETE) begin
      failures++; $display("FAIL wr_done done=%b err=%b rdata=%h state=%0d want 0010/0/0/3", done, err, rdata, dbg_state); end
    req = 4'b0000;
    tick();
    checks++; if (done !== 4'b0 || gnt !== 4'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL wr_pulse done=%b gnt=%b state=%0d want 0000/0000/0", done, gnt, dbg_state); end
    tick();
  endtask

  // Requester 0 reads with three data-phase wait states; pointer 2 wraps to 0
  task automatic test_read_wait();
    set_req(0, 1'b0, 32'h8000_0004, 32'h0BAD_F00D);
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001 || Htrans !== 2'b10 || Haddr !== 32'h8000_0004 || Hwrite !== 1'b0) begin
      failures++; $display("FAIL rd_addr gnt=%b Htrans=%b Haddr=%h Hwrite=%b want 0001/10/80000004/0", gnt, Htrans, Haddr, Hwrite); end
    tick();
    Hreadyout = 1'b0;
    Hrdata    = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (Htrans !== 2'b00 || done !== 4'b0 || dbg_state !== ST_DATA) begin
        failures++; $display("FAIL rd_wait%0d Htrans=%b done=%b state=%0d want 00/0000/2", k, Htrans, done, dbg_state); end
    end
    Hreadyout = 1'b1;
    Hrdata    = 32'h1234_5678;
    tick();
    checks++; if (done !== 4'b0001 || rdata !== 32'h1234_5678 || err !== 1'b0) begin
      failures++; $display("FAIL rd_done done=%b rdata=%h err=%b want 0001/12345678/0", done, rdata, err); end
    req = 4'b0000;
    tick();
    checks++; if (rdata !== 32'h1234_5678 || done !== 4'b0) begin
      failures++; $display("FAIL rd_hold rdata=%h done=%b want 12345678/0000", rdata, done); end
    tick();
  endtask

  // Requester 2 read gets ERROR, then requester 3 write gets OKAY; pointer ends at 0
  task automatic test_error();
    set_req(2, 1'b0, 32'h8000_0020, 32'h0);
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100 || Haddr !== 32'h8000_0020) begin
      failures++; $display("FAIL err_addr gnt=%b Haddr=%h want 0100/80000020", gnt, Haddr); end
    tick();
    Hresp  = 2'b01;
    Hrdata = 32'hAAAA_5555;
    tick();
    checks++; if (done !== 4'b0100 || err !== 1'b1 || rdata !== 32'hAAAA_5555) begin
      failures++; $display("FAIL err_done done=%b err=%b rdata=%h want 0100/1/aaaa5555", done, err, rdata); end
    req   = 4'b0000;
    Hresp = 2'b00;
    tick();
    tick();
    set_req(3, 1'b1, 32'h8000_0030, 32'hCAFE_0003);
    req = 4'b1000;
    tick();
    tick();
    tick();
    checks++; if (done !== 4'b1000 || err !== 1'b0 || rdata !== '0) begin
      failures++; $display("FAIL okay_after_err done=%b err=%b rdata=%h want 1000/0/0", done, err, rdata); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // All four request continuously; each drops for one cycle after its done
  task automatic test_round_robin();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int n;
    int w;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h9000_0000 + 32'(i * 4), 32'h5000_0000 + 32'(i));
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (gnt === 4'b0 && n < 20) begin tick(); n++; end
      w = exp_order[k];
      checks++; if (gnt !== (4'b0001 << w)) begin
        failures++; $display("FAIL rr_gnt%0d gnt=%b want %b", k, gnt, 4'b0001 << w); end
      n = 0;
      while (done === 4'b0 && n < 20) begin tick(); n++; end
      checks++; if (done !== (4'b0001 << w)) begin
        failures++; $display("FAIL rr_done%0d done=%b want %b", k, done, 4'b0001 << w); end
      req[w] = 1'b0;
      tick();
      req[w] = 1'b1;
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Pointer is 2 here; reset in DATA must clear outputs and restart from index 0
  task automatic test_reset_mid();
    set_req(2, 1'b1, 32'h8000_0040, 32'h7777_7777);
    req = 4'b0100;
    tick();
    tick();
    Hreadyout = 1'b0;
    tick();
    checks++; if (dbg_state !== ST_DATA || gnt !== 4'b0100) begin
      failures++; $display("FAIL mid_setup state=%0d gnt=%b want 2/0100", dbg_state, gnt); end
    Hresetn = 1'b0;
    #2;
    checks++; if (Htrans !== 2'b00 || gnt !== 4'b0 || done !== 4'b0 || Hwdata !== '0 || Hreadyin !== 1'b1) begin
      failures++; $display("FAIL async_rst Htrans=%b gnt=%b done=%b Hwdata=%h Hreadyin=%b want 00/0/0/0/1", Htrans, gnt, done, Hwdata, Hreadyin); end
    set_req(1, 1'b0, 32'h8000_0014, 32'h0);
    set_req(3, 1'b0, 32'h8000_0034, 32'h0);
    req       = 4'b1010;
    Hreadyout = 1'b1;
    #1;
    Hresetn = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0010 || Haddr !== 32'h8000_0014 || Htrans !== 2'b10) begin
      failures++; $display("FAIL post_rst_gnt gnt=%b Haddr=%h Htrans=%b want 0010/80000014/10", gnt, Haddr, Htrans); end
    tick();
    tick();
    checks++; if (done !== 4'b0010) begin
      failures++; $display("FAIL post_rst_done done=%b want 0010", done); end
    req = 4'b0000;
    tick();
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  // Requester 0 never sees Hreadyout; completes with error after 16 wait cycles
  task automatic test_timeout();
    int early;
    early = 0;
    set_req(0, 1'b0, 32'h8000_0050, 32'h0);
    Hreadyout = 1'b0;
    req = 4'b0001;
    tick();
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done !== 4'b0) early++;
    end
    checks++; if (early != 0) begin
      failures++; $display("FAIL to_early count=%0d want 0", early); end
    tick();
    checks++; if (done !== 4'b0001 || err !== 1'b1 || rdata !== '0) begin
      failures++; $display("FAIL to_done done=%b err=%b rdata=%h want 0001/1/0", done, err, rdata); end
    req = 4'b0000;
    Hreadyout = 1'b1;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_error();
    test_round_robin();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
